// File: rtl/exp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : exp_arbiter
//  Description : Two-requester round-robin front end for a single shared Exp
//                engine. One request is selected per job and its operand is
//                latched. The job is issued to the engine and its reply is
//                awaited under a watchdog timeout. The result then goes back
//                to the owning requester.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT    : maximum WAIT cycles without eng_done before abort (1..255)
//  Ports
//    clk        : clock, rising edge
//    rst        : asynchronous reset, active low
//    req0/req1  : level requests, held by the requester until its done pulse
//    x0/x1      : 16-bit operands of requester 0 / 1
//    gnt0/gnt1  : one-cycle grant pulse, coincident with eng_start
//    done0/done1: one-cycle completion pulse to the job owner
//    y          : 21-bit result of the last completed job (0 on timeout)
//    err        : set when the last completed job timed out
//    busy       : high whenever a job is in flight (not IDLE)
//    eng_start  : one-cycle start pulse to the engine
//    eng_x      : operand presented to the engine, stable for the whole job
//    eng_done   : engine completion pulse
//    eng_y      : engine result, valid with eng_done
// ============================================================================
module exp_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] x0,
    input  logic        req1,
    input  logic [15:0] x1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [20:0] y,
    output logic        err,
    output logic        busy,
    output logic        eng_start,
    output logic [15:0] eng_x,
    input  logic        eng_done,
    input  logic [20:0] eng_y
);

    // Last WAIT cycle count before the job is declared lost.
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_owner;   // requester that owns the job in flight
    logic       r_last;    // requester served most recently
    logic [7:0] r_timer;   // WAIT cycles elapsed without a reply

    logic w_any_req;
    logic w_pick;

    // A lone requester wins outright; on a tie the one not served last wins.
    assign w_any_req = req0 | req1;
    assign w_pick    = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;   // requester 0 wins the first tie
            r_timer   <= 8'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            y         <= 21'd0;
            err       <= 1'b0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            eng_x     <= 16'd0;
        end else begin
            // Pulses default low; each is raised for exactly one state.
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            eng_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick;
                        eng_x     <= w_pick ? x1 : x0;
                        gnt0      <= ~w_pick;
                        gnt1      <= w_pick;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_timer <= 8'd0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A reply on the final timeout cycle still counts as valid.
                    if (eng_done) begin
                        y       <= eng_y;
                        err     <= 1'b0;
                        done0   <= ~r_owner;
                        done1   <= r_owner;
                        r_state <= ST_RESP;
                    end else if (r_timer == c_TIMER_LAST) begin
                        y       <= 21'd0;
                        err     <= 1'b1;
                        done0   <= ~r_owner;
                        done1   <= r_owner;
                        r_state <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                ST_RESP: begin
                    r_last  <= r_owner;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/exp_arbiter.md
EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, max clk cycles WAIT holds for eng_done before aborting (1..255).
REQ-002 Port: clk  input  1  single clock, rising-edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: req0  input  1  requester 0 level request; held until done0.
REQ-005 Port: x0  input  16  requester 0 operand.
REQ-006 Port: req1  input  1  requester 1 level request; held until done1.
REQ-007 Port: x1  input  16  requester 1 operand.
REQ-008 Port: gnt0, gnt1  output  1 each  one-cycle grant pulse, coincident with eng_start.
REQ-009 Port: done0, done1  output  1 each  one-cycle completion pulse to owner.
REQ-010 Port: y  output  21  result of last completed job, held until next completion.
REQ-011 Port: err  output  1  set with done pulse when job timed out; held with y.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: eng_start  output  1  one-cycle start pulse to shared Exp engine.
REQ-014 Port: eng_x  output  16  registered operand to engine, stable from ISSUE until next ISSUE.
REQ-015 Port: eng_done  input  1  engine completion pulse.
REQ-016 Port: eng_y  input  21  engine result, valid when eng_done high.

Function
REQ-017 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transition per clk edge.
REQ-018 IDLE: if req0 or req1 high at an edge, SHALL select owner, latch its operand into eng_x, go ISSUE; else stay.
REQ-019 Selection SHALL be round-robin: one requester -> that one; both -> the one not equal to last-served pointer.
REQ-020 ISSUE: eng_start and gnt<owner> SHALL be high for exactly this one cycle; next state WAIT, timer cleared to 0.
REQ-021 WAIT: eng_done high -> capture eng_y into y, clear err, go RESP.
REQ-022 WAIT: timer SHALL increment each cycle without eng_done; at timer == TIMEOUT-1 with no eng_done -> y=0, err=1, go RESP.
REQ-023 eng_done and eng_done coincident with timeout: eng_done SHALL win (valid capture, err=0).
REQ-024 RESP: done<owner> high for exactly this cycle; last-served pointer := owner; next state IDLE.
REQ-025 eng_done in IDLE, ISSUE or RESP SHALL be ignored; y/err unchanged.
REQ-026 Requests dropped after selection SHALL not abort the job; done pulse still issued.
REQ-027 Operand changes on x0/x1 after selection SHALL not affect eng_x.
REQ-028 Latency: req seen at edge k -> eng_start cycle k+1; eng_done at cycle m -> done pulse cycle m+1; min req-to-done 3 cycles + engine latency.
REQ-029 Back-to-back: a request held through RESP SHALL be re-arbitrated in IDLE the next cycle (no starvation, alternation under sustained dual requests).
REQ-030 At most one of gnt0/gnt1 and one of done0/done1 SHALL be high in any cycle.

Reset
REQ-031 rst low SHALL immediately force IDLE, timer=0, last-served pointer=1 (req0 wins first tie), eng_x=0, y=0, err=0, all pulses and busy low.
REQ-032 rst asserted mid-job SHALL abandon the job with no done pulse; late eng_done after release SHALL be ignored (IDLE).
REQ-033 Release of rst SHALL take effect on the first clk edge after deassertion; no other state retained.

Verification
REQ-034 Single req0, x0=16'h8000, engine returns eng_y=21'h0ABCDE after 5 cycles -> gnt0 one pulse, eng_x=16'h8000, done0 one pulse, y=21'h0ABCDE, err=0.
REQ-035 req0 and req1 asserted same edge after reset, both held -> order gnt0, done0, gnt1, done1, gnt0 ... strictly alternating.
REQ-036 TIMEOUT=8, engine never answers -> done pulse exactly 8 cycles after WAIT entry, y=0, err=1; next job with reply clears err.
REQ-037 eng_done arriving on final timeout cycle -> valid y captured, err=0.
REQ-038 rst pulsed low during WAIT, then spurious eng_done -> no done pulse, y=0, busy=0, next req1 granted normally.
REQ-039 x0 changed and req0 dropped one cycle after grant -> eng_x holds original value, done0 still pulses.
